plate_registry: RTL

//  Downstream stage of the keypad plate-entry block: consumes its 24-bit plate word (6 x 4-bit digits,
//  0 = no plate yet) and keeps a table of parked vehicles. Entry stores plate + timestamp in a free

---
 rtl/plate_registry_if.sv | 31 +++
 rtl/plate_registry.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/plate_registry_if.sv
// Request/response bundle between the plate-entry stage and the plate registry.
// The tarifa signal exists only when PLATE_FEE_EN is defined.
interface plate_registry_if #(
  parameter int SLOTS  = 8,
  parameter int TIME_W = 16
);
  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int LW = $clog2(SLOTS + 1);

  logic [23:0]       placa;
  logic              modo;
  logic              busy;
  logic              done;
  logic [2:0]        result;
  logic [IW-1:0]     slot_idx;
  logic [TIME_W-1:0] tiempo;
  logic [LW-1:0]     libres;
`ifdef PLATE_FEE_EN
  logic [15:0]       tarifa;

  modport master (output placa, modo,
                  input  busy, done, result, slot_idx, tiempo, libres, tarifa);
  modport slave  (input  placa, modo,
                  output busy, done, result, slot_idx, tiempo, libres, tarifa);
`else
  modport master (output placa, modo,
                  input  busy, done, result, slot_idx, tiempo, libres);
  modport slave  (input  placa, modo,
                  output busy, done, result, slot_idx, tiempo, libres);
`endif
endinterface

// File: rtl/plate_registry.sv
// Parking table: entry stores plate+timestamp in a free slot, exit frees it and reports parked time.
// Optional fee output (tiempo*RATE, saturated) is enabled by defining PLATE_FEE_EN.
module plate_registry #(
  parameter int SLOTS    = 8,
  parameter int TICK_DIV = 50_000_000,
  parameter int TIME_W   = 16,
  parameter int RATE     = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  plate_registry_if.slave bus
);
  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int LW = $clog2(SLOTS + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] R_NONE     = 3'd0;
  localparam logic [2:0] R_OK_IN    = 3'd1;
  localparam logic [2:0] R_OK_OUT   = 3'd2;
  localparam logic [2:0] R_FULL     = 3'd3;
  localparam logic [2:0] R_DUP      = 3'd4;
  localparam logic [2:0] R_NOTFOUND = 3'd5;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, REPORT} state_t;
  state_t st, st_nx;

  // time base
  logic [PW-1:0]     presc;
  logic [TIME_W-1:0] now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      now   <= '0;
    end else if (presc == PW'(TICK_DIV - 1)) begin
      presc <= '0;
      now   <= now + TIME_W'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // table
  logic [SLOTS-1:0]  valid;
  logic [23:0]       plate_tab [SLOTS];
  logic [TIME_W-1:0] stamp_tab [SLOTS];

  // operation context
  logic [23:0]       placa_prev, lat_plate;
  logic              lat_modo;
  logic [IW-1:0]     scan_idx, hit_idx, free_idx;
  logic              hit, free_ok;
  logic [LW-1:0]     libres_q;
  logic [2:0]        pend_res;
  logic [IW-1:0]     pend_idx;
  logic [TIME_W-1:0] pend_t;

  logic trig, scan_en, commit_en, report_en, do_store, do_free;
  logic cur_match, cur_free;

  // Edge-detect on the plate word: a completed plate arriving while idle.
  assign trig = (st == IDLE) && (bus.placa != '0) && (placa_prev == '0);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  // FSM: next state
  always_comb begin
    st_nx = st;
    case (st)
      IDLE:    if (trig) st_nx = SCAN;
      SCAN:    if (scan_idx == IW'(SLOTS - 1)) st_nx = COMMIT;
      COMMIT:  st_nx = REPORT;
      REPORT:  st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    scan_en   = 1'b0;
    commit_en = 1'b0;
    report_en = 1'b0;
    case (st)
      SCAN:    scan_en   = 1'b1;
      COMMIT:  commit_en = 1'b1;
      REPORT:  report_en = 1'b1;
      default: ;
    endcase
  end

  assign cur_match = valid[scan_idx] && (plate_tab[scan_idx] == lat_plate);
  assign cur_free  = !valid[scan_idx];
  assign do_store  = commit_en && !lat_modo && !hit && free_ok;
  assign do_free   = commit_en &&  lat_modo &&  hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      placa_prev <= '0;
      lat_plate  <= '0;
      lat_modo   <= 1'b0;
      scan_idx   <= '0;
      hit        <= 1'b0;
      hit_idx    <= '0;
      free_ok    <= 1'b0;
      free_idx   <= '0;
    end else begin
      placa_prev <= bus.placa;
      if (trig) begin
        lat_plate <= bus.placa;
        lat_modo  <= bus.modo;
        scan_idx  <= '0;
        hit       <= 1'b0;
        hit_idx   <= '0;
        free_ok   <= 1'b0;
        free_idx  <= '0;
      end else if (scan_en) begin
        scan_idx <= scan_idx + IW'(1);
        // keep the first match and the lowest free slot only
        if (cur_match && !hit) begin
          hit     <= 1'b1;
          hit_idx <= scan_idx;
        end
        if (cur_free && !free_ok) begin
          free_ok  <= 1'b1;
          free_idx <= scan_idx;
        end
      end
    end
  end

  // Payload storage needs no reset: valid gates every read.
  always_ff @(posedge clk) begin
    if (do_store) begin
      plate_tab[free_idx] <= lat_plate;
      stamp_tab[free_idx] <= now;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      libres_q <= LW'(SLOTS);
      pend_res <= R_NONE;
      pend_idx <= '0;
      pend_t   <= '0;
    end else if (commit_en) begin
      pend_idx <= '0;
      pend_t   <= '0;
      if (!lat_modo) begin
        if (hit) begin
          pend_res <= R_DUP;
          pend_idx <= hit_idx;
        end else if (!free_ok) begin
          pend_res <= R_FULL;
        end else begin
          valid[free_idx] <= 1'b1;
          libres_q        <= libres_q - LW'(1);
          pend_res        <= R_OK_IN;
          pend_idx        <= free_idx;
        end
      end else if (do_free) begin
        valid[hit_idx] <= 1'b0;
        libres_q       <= libres_q + LW'(1);
        pend_res       <= R_OK_OUT;
        pend_idx       <= hit_idx;
        pend_t         <= now - stamp_tab[hit_idx];
      end else begin
        pend_res <= R_NOTFOUND;
      end
    end
  end

  // reported outputs, held until the next done
  logic              busy_q, done_q;
  logic [2:0]        result_q;
  logic [IW-1:0]     idx_q;
  logic [TIME_W-1:0] tiempo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= R_NONE;
      idx_q    <= '0;
      tiempo_q <= '0;
    end else begin
      busy_q <= (st != IDLE);
      done_q <= report_en;
      if (report_en) begin
        result_q <= pend_res;
        idx_q    <= pend_idx;
        tiempo_q <= pend_t;
      end
    end
  end

`ifdef PLATE_FEE_EN
  localparam int FW = TIME_W + 32;
  logic [FW-1:0] fee_prod;
  logic [15:0]   fee_sat, tarifa_q;

  assign fee_prod = FW'(pend_t) * FW'(RATE);
  assign fee_sat  = (|fee_prod[FW-1:16]) ? 16'hFFFF : fee_prod[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         tarifa_q <= '0;
    else if (report_en) tarifa_q <= (pend_res == R_OK_OUT) ? fee_sat : 16'h0;
  end

  assign bus.tarifa = tarifa_q;
`endif

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.slot_idx = idx_q;
  assign bus.tiempo   = tiempo_q;
  assign bus.libres   = libres_q;
endmodule
